// File: rtl/ad_da_spi_sched_if.sv
// ad_da_spi_sched_if: user-side request/ack/data signals plus converter bus pins.
// Latency: none, wiring only.
// Backpressure: a requester holds its req until the matching ack pulse.
// slave  : the scheduler. Inputs are the reqs, dac_data, adc_cmd and miso.
//          Outputs are the acks, adc_data/adc_valid, busy, sclk, cs_*_n and mosi.
// master : the user logic / board side, with the opposite directions.
interface ad_da_spi_sched_if;
  logic        dac_req;
  logic [15:0] dac_data;
  logic        dac_ack;
  logic        adc_req;
  logic [15:0] adc_cmd;
  logic        adc_ack;
  logic [15:0] adc_data;
  logic        adc_valid;
  logic        busy;
  logic        sclk;
  logic        cs_dac_n;
  logic        cs_adc_n;
  logic        mosi;
  logic        miso;

  modport slave (
    input  dac_req, dac_data, adc_req, adc_cmd, miso,
    output dac_ack, adc_ack, adc_data, adc_valid, busy,
           sclk, cs_dac_n, cs_adc_n, mosi
  );

  modport master (
    output dac_req, dac_data, adc_req, adc_cmd, miso,
    input  dac_ack, adc_ack, adc_data, adc_valid, busy,
           sclk, cs_dac_n, cs_adc_n, mosi
  );
endinterface

// File: rtl/ad_da_spi_sched.sv
// ad_da_spi_sched: round-robin DAC-write / ADC-read scheduler on one shared SPI bus (CPOL=1, CPHA=1).
// Latency: ack 1 clk after req; cs_n low 1 clk after ack for CLK_DIV*34 clks; grant-to-grant 1+CLK_DIV*34+GAP_CYC.
// Backpressure: requests are held off while busy and arbitrated again on the first IDLE cycle.
// Ports: clk, rst (sync, active high); bus (slave modport): dac_req/dac_data/dac_ack,
//        adc_req/adc_cmd/adc_ack, adc_data/adc_valid, busy, sclk, cs_dac_n, cs_adc_n, mosi, miso.
module ad_da_spi_sched #(
  parameter int CLK_DIV = 2,  // clk cycles per SCLK half-period
  parameter int GAP_CYC = 2   // clk cycles with both chip-selects high between frames
) (
  input  logic             clk,
  input  logic             rst,
  ad_da_spi_sched_if.slave bus
);
  localparam int HW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int GW = (GAP_CYC > 0) ? $clog2(GAP_CYC + 1) : 1;

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

  state_t          state, state_nx;
  logic [HW-1:0]   half_cnt;
  logic [5:0]      edge_cnt;   // SCLK half-period index inside SHIFT, 0..31
  logic [GW-1:0]   gap_cnt;
  logic [15:0]     shreg;
  logic [15:0]     rx;
  logic            tgt_adc;    // target of the current frame
  logic            last_adc;   // last grant went to the ADC
  logic            grant_dac, grant_adc, half_end, gap_end, frame_on;

  always_comb begin
    // On a tie the requester that did not win last time takes the bus.
    grant_dac = bus.dac_req && (!bus.adc_req || last_adc);
    grant_adc = bus.adc_req && !grant_dac;
    half_end  = (half_cnt == HW'(CLK_DIV - 1));
    gap_end   = (gap_cnt == GW'(GAP_CYC - 1));
    frame_on  = (state == SETUP) || (state == SHIFT) || (state == HOLD);
    state_nx  = state;
    case (state)
      IDLE:    if (grant_dac || grant_adc)        state_nx = SETUP;
      SETUP:   if (half_end)                      state_nx = SHIFT;
      SHIFT:   if (half_end && edge_cnt == 6'd31) state_nx = HOLD;
      HOLD:    if (half_end)                      state_nx = GAP;
      GAP:     if (gap_end)                       state_nx = IDLE;
      default:                                    state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Pin outputs are registered from the current state, so the bus trails the
  // state register by one clk: cs_n falls the cycle after the ack pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      half_cnt      <= '0;
      edge_cnt      <= '0;
      gap_cnt       <= '0;
      shreg         <= '0;
      rx            <= '0;
      tgt_adc       <= 1'b0;
      last_adc      <= 1'b1;
      bus.dac_ack   <= 1'b0;
      bus.adc_ack   <= 1'b0;
      bus.adc_data  <= '0;
      bus.adc_valid <= 1'b0;
      bus.busy      <= 1'b0;
      bus.sclk      <= 1'b1;
      bus.cs_dac_n  <= 1'b1;
      bus.cs_adc_n  <= 1'b1;
      bus.mosi      <= 1'b0;
    end else begin
      bus.dac_ack   <= (state == IDLE) && grant_dac;
      bus.adc_ack   <= (state == IDLE) && grant_adc;
      bus.busy      <= (state_nx != IDLE);
      bus.adc_valid <= 1'b0;

      if (state_nx != state) begin
        half_cnt <= '0;
        edge_cnt <= '0;
        gap_cnt  <= '0;
      end else begin
        case (state)
          SETUP, HOLD: half_cnt <= half_cnt + 1'b1;
          SHIFT: begin
            if (half_end) begin
              half_cnt <= '0;
              edge_cnt <= edge_cnt + 6'd1;
            end else begin
              half_cnt <= half_cnt + 1'b1;
            end
          end
          GAP:     gap_cnt <= gap_cnt + 1'b1;
          default: ;
        endcase
      end

      if (state == IDLE && (grant_dac || grant_adc)) begin
        shreg    <= grant_dac ? bus.dac_data : bus.adc_cmd;
        tgt_adc  <= grant_adc;
        last_adc <= grant_adc;
      end else if (state == SHIFT && edge_cnt[0] && half_end && edge_cnt != 6'd31) begin
        // Advance at the end of each high half so the next bit is on mosi
        // when sclk falls; bit0 stays put through HOLD.
        shreg <= {shreg[14:0], 1'b0};
      end

      // Sample on the same edge that drives sclk 0->1; DAC frames ignore miso.
      if (state == SHIFT && edge_cnt[0] && half_cnt == '0 && tgt_adc)
        rx <= {rx[14:0], bus.miso};

      bus.sclk     <= !(state == SHIFT && !edge_cnt[0]);
      bus.cs_dac_n <= !(frame_on && !tgt_adc);
      bus.cs_adc_n <= !(frame_on && tgt_adc);
      bus.mosi     <= frame_on ? shreg[15] : 1'b0;

      if (state == GAP && gap_cnt == '0 && tgt_adc) begin
        bus.adc_data  <= rx;
        bus.adc_valid <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_ad_da_spi_sched.sv
// tb_ad_da_spi_sched: directed bench for the scheduler at default divisors and at CLK_DIV=1/GAP_CYC=1.
// Latency: samples all outputs on the falling clk edge, one sample per clk cycle.
// Backpressure: requests drop on their ack unless a test holds them high.
module tb_ad_da_spi_sched;
  logic clk;
  logic rst;
  logic sel;        // 0: observe default build, 1: observe CLK_DIV=1 build
  logic auto_drop;  // release a request in the cycle its ack is seen

  ad_da_spi_sched_if b0 ();
  ad_da_spi_sched_if b1 ();

  ad_da_spi_sched #(.CLK_DIV(2), .GAP_CYC(2)) u_dut  (.clk(clk), .rst(rst), .bus(b0));
  ad_da_spi_sched #(.CLK_DIV(1), .GAP_CYC(1)) u_dut1 (.clk(clk), .rst(rst), .bus(b1));

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // ADC model on the default build: CPHA=1 slave, next bit out on each falling sclk.
  logic [15:0] mdl_word;
  logic        mdl_miso;
  int          mdl_idx;
  initial begin
    mdl_word = 16'h3E7F;
    mdl_miso = 1'b1;
    mdl_idx  = 0;
  end
  always @(negedge b0.cs_adc_n) mdl_idx = 0;
  always @(negedge b0.sclk) begin
    if (!b0.cs_adc_n && mdl_idx < 16) begin
      mdl_miso = mdl_word[15 - mdl_idx];
      mdl_idx  = mdl_idx + 1;
    end
  end
  assign b0.miso = mdl_miso;
  assign b1.miso = b1.mosi;  // loopback on the fast build

  wire        s_sclk   = sel ? b1.sclk      : b0.sclk;
  wire        s_csd    = sel ? b1.cs_dac_n  : b0.cs_dac_n;
  wire        s_csa    = sel ? b1.cs_adc_n  : b0.cs_adc_n;
  wire        s_mosi   = sel ? b1.mosi      : b0.mosi;
  wire        s_dack   = sel ? b1.dac_ack   : b0.dac_ack;
  wire        s_aack   = sel ? b1.adc_ack   : b0.adc_ack;
  wire        s_valid  = sel ? b1.adc_valid : b0.adc_valid;
  wire        s_busy   = sel ? b1.busy      : b0.busy;
  wire [15:0] s_data   = sel ? b1.adc_data  : b0.adc_data;

  int n_chk, n_err;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Observation state gathered by watch().
  int          cyc;
  int          dac_acks, adc_acks, dac_ack_cyc, adc_ack_cyc;
  int          cs_lo_dac, cs_lo_adc, first_cs_lo, overlap;
  int          falls, rises, first_fall, valids, valid_at_rise, busy_cnt;
  logic [15:0] mosi_cap, valid_data;
  logic        p_sclk, p_csa;
  int          grants[$];

  task automatic clr();
    dac_acks = 0; adc_acks = 0; dac_ack_cyc = -1; adc_ack_cyc = -1;
    cs_lo_dac = 0; cs_lo_adc = 0; first_cs_lo = -1; overlap = 0;
    falls = 0; rises = 0; first_fall = -1; valids = 0; valid_at_rise = 0;
    busy_cnt = 0; mosi_cap = '0; valid_data = '0;
    p_sclk = s_sclk; p_csa = s_csa;
    grants.delete();
  endtask

  task automatic watch(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cyc++;
      if (s_dack) begin
        dac_acks++;
        if (dac_ack_cyc < 0) dac_ack_cyc = cyc;
        grants.push_back(cyc * 2);
        if (auto_drop) begin
          if (sel) b1.dac_req = 1'b0; else b0.dac_req = 1'b0;
        end
      end
      if (s_aack) begin
        adc_acks++;
        if (adc_ack_cyc < 0) adc_ack_cyc = cyc;
        grants.push_back(cyc * 2 + 1);
        if (auto_drop) begin
          if (sel) b1.adc_req = 1'b0; else b0.adc_req = 1'b0;
        end
      end
      if (!s_csd) cs_lo_dac++;
      if (!s_csa) cs_lo_adc++;
      if ((!s_csd || !s_csa) && first_cs_lo < 0) first_cs_lo = cyc;
      if (!s_csd && !s_csa) overlap++;
      if (p_sclk && !s_sclk) begin
        falls++;
        if (first_fall < 0) first_fall = cyc;
      end
      if (!p_sclk && s_sclk) begin
        rises++;
        mosi_cap = {mosi_cap[14:0], s_mosi};
      end
      if (s_valid) begin
        valids++;
        valid_data = s_data;
        if (s_csa && !p_csa) valid_at_rise++;
      end
      if (s_busy) busy_cnt++;
      p_sclk = s_sclk;
      p_csa  = s_csa;
    end
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (s_busy && n < 300) begin
      watch(1);
      n++;
    end
    chk(tag, s_busy, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk = 0; n_err = 0; cyc = 0;
    sel = 1'b0; auto_drop = 1'b1;
    rst = 1'b1;
    b0.dac_req = 1'b0; b0.adc_req = 1'b0; b0.dac_data = '0; b0.adc_cmd = '0;
    b1.dac_req = 1'b0; b1.adc_req = 1'b0; b1.dac_data = '0; b1.adc_cmd = '0;
    repeat (3) @(negedge clk);

    // Reset values
    chk("rst_sclk",      b0.sclk, 1'b1);
    chk("rst_cs_dac",    b0.cs_dac_n, 1'b1);
    chk("rst_cs_adc",    b0.cs_adc_n, 1'b1);
    chk("rst_mosi",      b0.mosi, 1'b0);
    chk("rst_busy",      b0.busy, 1'b0);
    chk("rst_acks",      {b0.dac_ack, b0.adc_ack}, 2'b00);
    chk("rst_valid",     b0.adc_valid, 1'b0);
    chk("rst_adc_data",  b0.adc_data, 16'h0000);
    chk("rst_fast_sclk", b1.sclk, 1'b1);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Single DAC write
    clr();
    b0.dac_data = 16'hA5C3; b0.dac_req = 1'b1;
    watch(90);
    chk("t1_dac_acks",   dac_acks, 1);
    chk("t1_adc_acks",   adc_acks, 0);
    chk("t1_cs_lo",      cs_lo_dac, 68);
    chk("t1_cs_after",   first_cs_lo - dac_ack_cyc, 1);
    chk("t1_falls",      falls, 16);
    chk("t1_rises",      rises, 16);
    chk("t1_first_fall", first_fall - first_cs_lo, 2);
    chk("t1_mosi",       mosi_cap, 16'hA5C3);
    chk("t1_cs_adc",     cs_lo_adc, 0);
    chk("t1_valid",      valids, 0);
    chk("t1_busy_len",   busy_cnt, 70);
    chk("t1_adc_data",   b0.adc_data, 16'h0000);

    // Single ADC read, model answers 3E7F
    clr();
    b0.adc_cmd = 16'h8000; b0.adc_req = 1'b1;
    watch(90);
    chk("t2_adc_acks",   adc_acks, 1);
    chk("t2_cs_lo",      cs_lo_adc, 68);
    chk("t2_cs_dac",     cs_lo_dac, 0);
    chk("t2_mosi",       mosi_cap, 16'h8000);
    chk("t2_valids",     valids, 1);
    chk("t2_valid_data", valid_data, 16'h3E7F);
    chk("t2_valid_time", valid_at_rise, 1);
    chk("t2_adc_data",   b0.adc_data, 16'h3E7F);

    // Both requests held from reset: DAC first, then alternate every 71 cycles
    rst = 1'b1;
    b0.dac_req = 1'b1; b0.adc_req = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    auto_drop = 1'b0;
    clr();
    watch(230);
    b0.dac_req = 1'b0; b0.adc_req = 1'b0;
    auto_drop = 1'b1;
    chk("t3_ngrants", (grants.size() >= 4), 1'b1);
    if (grants.size() >= 4) begin
      for (int i = 0; i < 4; i++)
        chk($sformatf("t3_type%0d", i), grants[i] & 1, i & 1);
      for (int i = 0; i < 3; i++)
        chk($sformatf("t3_space%0d", i), (grants[i+1] >> 1) - (grants[i] >> 1), 71);
    end
    chk("t3_overlap", overlap, 0);
    wait_idle("t3_idle");

    // ADC request raised in the middle of a DAC frame
    clr();
    b0.dac_data = 16'h0F0F; b0.dac_req = 1'b1;
    watch(30);
    b0.adc_cmd = 16'h8000; b0.adc_req = 1'b1;
    watch(120);
    chk("t4_acks",       {dac_acks[3:0], adc_acks[3:0]}, 8'h11);
    chk("t4_adc_grant",  adc_ack_cyc - dac_ack_cyc, 71);
    chk("t4_overlap",    overlap, 0);
    chk("t4_cs_dac",     cs_lo_dac, 68);
    chk("t4_cs_adc",     cs_lo_adc, 68);
    chk("t4_valid_data", valid_data, 16'h3E7F);

    // Reset at SCLK edge 10 of a DAC frame
    clr();
    b0.dac_data = 16'hA5C3; b0.dac_req = 1'b1;
    begin
      int n;
      n = 0;
      while ((falls + rises) < 10 && n < 100) begin
        watch(1);
        n++;
      end
    end
    chk("t5_edge10", falls + rises, 10);
    rst = 1'b1;
    @(negedge clk);
    chk("t5_sclk", b0.sclk, 1'b1);
    chk("t5_cs",   {b0.cs_dac_n, b0.cs_adc_n}, 2'b11);
    chk("t5_busy", b0.busy, 1'b0);
    chk("t5_mosi", b0.mosi, 1'b0);
    rst = 1'b0;
    clr();
    watch(5);
    chk("t5_no_retry", dac_acks + adc_acks, 0);
    clr();
    b0.dac_data = 16'h5A3C; b0.dac_req = 1'b1;
    watch(90);
    chk("t5_acks",  dac_acks, 1);
    chk("t5_cs_lo", cs_lo_dac, 68);
    chk("t5_falls", falls, 16);
    chk("t5_mosi",  mosi_cap, 16'h5A3C);

    // CLK_DIV=1, GAP_CYC=1 build with MISO looped to MOSI
    sel = 1'b1;
    #1;
    clr();
    b1.adc_cmd = 16'h1234; b1.adc_req = 1'b1;
    watch(50);
    chk("t6_acks",       adc_acks, 1);
    chk("t6_cs_lo",      cs_lo_adc, 34);
    chk("t6_falls",      falls, 16);
    chk("t6_first_fall", first_fall - first_cs_lo, 1);
    chk("t6_mosi",       mosi_cap, 16'h1234);
    chk("t6_valids",     valids, 1);
    chk("t6_valid_data", valid_data, 16'h1234);
    chk("t6_valid_time", valid_at_rise, 1);
    chk("t6_busy_len",   busy_cnt, 35);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
